// File: rtl/mem32_word_reader.sv
// Reads a 32-bit word from the byte-serial memory as four byte reads and
// returns it on a valid/ready response port, aborting if the memory stays busy too long.
module mem32_word_reader #(
    parameter int ADDR_W     = 4,
    parameter int TIMEOUT    = 15,
    parameter int BIG_ENDIAN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_dout,
    input  logic              mem_busy,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err
);

    // state     | meaning
    // S_IDLE    | waiting for a request, req_ready high
    // S_ISSUE   | strobing the read for byte idx unless the memory is busy
    // S_CAPTURE | memory returns byte idx this cycle, write it into its lane
    // S_RESP    | word (or timeout error) presented until rsp_ready
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [7:0]          wait_q, wait_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [31:0]         data_q, data_d;
    logic [31:0]         rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;

    logic [1:0]          lane;
    logic [31:0]         data_ins;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 2'd0;
            wait_q     <= 8'd0;
            base_q     <= '0;
            data_q     <= 32'd0;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wait_q     <= wait_d;
            base_q     <= base_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        base_d     = base_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;

        lane     = (BIG_ENDIAN != 0) ? (2'd3 - idx_q) : idx_q;
        data_ins = data_q;
        data_ins[{lane, 3'b000} +: 8] = mem_dout;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    base_d    = req_addr;
                    idx_d     = 2'd0;
                    wait_d    = 8'd0;
                    data_d    = 32'd0;
                    rsp_err_d = 1'b0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_busy) begin
                    wait_d = wait_q + 8'd1;
                    // Abort on the busy cycle that brings the count to TIMEOUT
                    if (wait_q + 8'd1 == TIMEOUT_CNT) begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = 32'd0;
                        state_d    = S_RESP;
                    end
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                data_d = data_ins;
                wait_d = 8'd0;
                if (idx_q == 2'd3) begin
                    rsp_data_d = data_ins;
                    state_d    = S_RESP;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_ISSUE;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Gating with rst keeps req_ready low while reset is asserted
    assign req_ready = (state_q == S_IDLE) && rst;
    assign mem_rd    = (state_q == S_ISSUE) && !mem_busy;
    assign mem_addr  = base_q + ADDR_W'(idx_q);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem32_word_reader.sv
// Directed bench for mem32_word_reader: a big-endian and a little-endian instance
// share stimulus; expected words are queued at request time and popped at response.
module tb_mem32_word_reader;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [3:0]  req_addr;
    logic        mem_busy;
    logic        rsp_ready;
    logic [7:0]  mem_dout;

    logic        req_ready_be, req_ready_le;
    logic        mem_rd_be, mem_rd_le;
    logic [3:0]  mem_addr_be, mem_addr_le;
    logic        rsp_valid_be, rsp_valid_le;
    logic [31:0] rsp_data_be, rsp_data_le;
    logic        rsp_err_be, rsp_err_le;

    typedef struct packed {
        logic [31:0] be;
        logic [31:0] le;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_asrt = 0;
    int   n_fail = 0;

    mem32_word_reader #(.ADDR_W(4), .TIMEOUT(TIMEOUT), .BIG_ENDIAN(1)) dut_be (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready_be), .req_addr(req_addr),
        .mem_rd(mem_rd_be), .mem_addr(mem_addr_be), .mem_dout(mem_dout), .mem_busy(mem_busy),
        .rsp_valid(rsp_valid_be), .rsp_ready(rsp_ready), .rsp_data(rsp_data_be), .rsp_err(rsp_err_be)
    );

    mem32_word_reader #(.ADDR_W(4), .TIMEOUT(TIMEOUT), .BIG_ENDIAN(0)) dut_le (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready_le), .req_addr(req_addr),
        .mem_rd(mem_rd_le), .mem_addr(mem_addr_le), .mem_dout(mem_dout), .mem_busy(mem_busy),
        .rsp_valid(rsp_valid_le), .rsp_ready(rsp_ready), .rsp_data(rsp_data_le), .rsp_err(rsp_err_le)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: byte i holds 8'h10 + i, returned the cycle after the strobe
    always @(posedge clk) begin
        if (mem_rd_be) mem_dout <= 8'h10 + {4'h0, mem_addr_be};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // bb/nb: nb busy cycles ahead of byte bb; tmo: busy from byte bb forever.
    // hold: cycles with rsp_ready low, req_valid held high (next_addr) meanwhile.
    task automatic do_read(input logic [3:0] addr, input int bb, input int nb,
                           input bit tmo, input int hold, input logic [3:0] next_addr);
        logic [7:0]  b [4];
        logic [3:0]  a;
        exp_t        e, got;
        int          rsp_cyc;
        bit          busy_now, exp_rd;
        int          exp_k;
        int          pk;
        for (int k = 0; k < 4; k++) begin
            a    = addr + 4'(k);
            b[k] = 8'h10 + {4'h0, a};
        end
        e.be  = tmo ? 32'd0 : {b[0], b[1], b[2], b[3]};
        e.le  = tmo ? 32'd0 : {b[3], b[2], b[1], b[0]};
        e.err = tmo;
        sb_q.push_back(e);

        chk("req_ready_idle", {31'd0, req_ready_be}, 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        mem_busy  = 1'b0;
        tick();
        req_valid = 1'b0;
        rsp_cyc   = tmo ? (2 * bb + 1 + TIMEOUT) : (9 + nb);

        for (int c = 1; c < rsp_cyc; c++) begin
            busy_now = tmo ? (c >= 2 * bb + 1)
                           : (nb > 0 && c >= 2 * bb + 1 && c < 2 * bb + 1 + nb);
            mem_busy = busy_now;
            #1;
            exp_rd = 1'b0;
            exp_k  = 0;
            for (int k = 0; k < 4; k++) begin
                pk = 2 * k + 1 + ((k >= bb) ? nb : 0);
                if (c == pk && (!tmo || k < bb)) begin
                    exp_rd = 1'b1;
                    exp_k  = k;
                end
            end
            chk($sformatf("mem_rd_be c%0d", c), {31'd0, mem_rd_be}, {31'd0, exp_rd});
            chk($sformatf("mem_rd_le c%0d", c), {31'd0, mem_rd_le}, {31'd0, exp_rd});
            if (exp_rd) chk($sformatf("mem_addr k%0d", exp_k), {28'd0, mem_addr_be}, {28'd0, addr + 4'(exp_k)});
            chk($sformatf("rsp_valid_early c%0d", c), {31'd0, rsp_valid_be}, 32'd0);
            if (c == 1) begin
                chk("req_ready_busy", {31'd0, req_ready_be}, 32'd0);
                chk("rsp_err_cleared", {31'd0, rsp_err_be}, 32'd0);
            end
            @(posedge clk);
            #1;
        end

        mem_busy = 1'b0;
        #1;
        chk("rsp_valid_be", {31'd0, rsp_valid_be}, 32'd1);
        chk("rsp_valid_le", {31'd0, rsp_valid_le}, 32'd1);
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            got = e;
        end else begin
            got = sb_q.pop_front();
        end
        chk("rsp_data_be", rsp_data_be, got.be);
        chk("rsp_data_le", rsp_data_le, got.le);
        chk("rsp_err_be", {31'd0, rsp_err_be}, {31'd0, got.err});
        chk("rsp_err_le", {31'd0, rsp_err_le}, {31'd0, got.err});

        rsp_ready = 1'b0;
        if (hold > 0) begin
            req_valid = 1'b1;
            req_addr  = next_addr;
        end
        for (int h = 0; h < hold; h++) begin
            #1;
            chk($sformatf("hold_valid h%0d", h), {31'd0, rsp_valid_be}, 32'd1);
            chk($sformatf("hold_data h%0d", h), rsp_data_be, got.be);
            chk($sformatf("hold_req_ready h%0d", h), {31'd0, req_ready_be}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        chk("rsp_valid_after_hs", {31'd0, rsp_valid_be}, 32'd0);
        chk("req_ready_after_hs", {31'd0, req_ready_be}, 32'd1);
        chk("rsp_data_kept", rsp_data_be, got.be);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_addr  = 4'd0;
        mem_busy  = 1'b0;
        rsp_ready = 1'b0;
        #2;
        chk("rst_req_ready", {31'd0, req_ready_be}, 32'd0);
        chk("rst_mem_rd", {31'd0, mem_rd_be}, 32'd0);
        chk("rst_mem_addr", {28'd0, mem_addr_be}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid_be}, 32'd0);
        chk("rst_rsp_data", rsp_data_be, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err_be}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("req_ready_after_rst", {31'd0, req_ready_be}, 32'd1);
        tick();

        do_read(4'd0,  0, 0, 1'b0, 0, 4'd0);
        do_read(4'd14, 0, 0, 1'b0, 0, 4'd0);
        do_read(4'd0,  1, 3, 1'b0, 0, 4'd0);
        do_read(4'd8,  1, 0, 1'b1, 0, 4'd0);
        do_read(4'd4,  0, 0, 1'b0, 4, 4'd2);
        do_read(4'd2,  0, 0, 1'b0, 0, 4'd0);

        req_valid = 1'b1;
        req_addr  = 4'd0;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        chk("pre_reset_mem_rd", {31'd0, mem_rd_be}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_mem_rd", {31'd0, mem_rd_be}, 32'd0);
        chk("midrst_rsp_valid", {31'd0, rsp_valid_be}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready_be}, 32'd0);
        chk("midrst_mem_addr", {28'd0, mem_addr_be}, 32'd0);
        chk("midrst_rsp_data", rsp_data_be, 32'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("postrst_rsp_valid", {31'd0, rsp_valid_be}, 32'd0);
        tick();
        do_read(4'd4, 0, 0, 1'b0, 0, 4'd0);

        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/mem32_word_reader.md
Name: mem32_word_reader

Overview:
- Read-side initiator for the team's byte-serial 16-byte memory, which is written as 32-bit words and read back one byte at a time.
- Accepts a 32-bit word read request at a byte address and issues four byte reads to the memory.
- Honours the memory busy flag and reassembles the returned bytes into one 32-bit word.
- Delivers the word through a valid/ready response port, with a timeout error when the memory stays busy.

Parameters:
- ADDR_W, 4, memory byte-address width; addresses wrap modulo 2^ADDR_W.
- TIMEOUT, 15, maximum consecutive busy cycles tolerated per byte before aborting with an error; legal range 1..255.
- BIG_ENDIAN, 1: 1 puts byte at base address in rsp_data[31:24]; 0 puts it in rsp_data[7:0].

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (0 = reset)
- req_valid  input  1  read request present
- req_ready  output  1  request accepted when req_valid & req_ready
- req_addr  input  ADDR_W  base byte address of word
- mem_rd  output  1  one-cycle byte read strobe to memory
- mem_addr  output  ADDR_W  byte address for current read
- mem_dout  input  8  byte returned by memory, valid the cycle after mem_rd
- mem_busy  input  1  memory cannot accept a read this cycle
- rsp_valid  output  1  response word available
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  32  assembled word
- rsp_err  output  1  response aborted by timeout; rsp_data = 0

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; byte index, wait counter, base address and data register all clear to 0.
  - Outputs during reset: req_ready=0, mem_rd=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0.
  - After release, req_ready=1 from the first clock edge onward.
- FSM states IDLE, ISSUE, CAPTURE, RESP:
  - IDLE: req_ready=1. On req_valid, latch req_addr as base, clear idx and wait counter, clear data register, go to ISSUE.
  - ISSUE:
    - mem_addr = (base + idx) mod 2^ADDR_W.
    - mem_rd = !mem_busy, combinational from state and mem_busy.
    - If mem_busy=1: stay and increment the wait counter. When the counter reaches TIMEOUT, go to RESP with rsp_err=1 and data=0.
    - If mem_busy=0: go to CAPTURE.
  - CAPTURE:
    - mem_rd=0; mem_addr is held.
    - Write mem_dout into byte lane idx: lane 3-idx if BIG_ENDIAN=1, lane idx otherwise.
    - Clear the wait counter.
    - If idx=3, go to RESP; else increment idx and go to ISSUE.
  - RESP: rsp_valid=1; rsp_data and rsp_err held stable until rsp_ready=1, then go to IDLE.
- Registers:
  - rsp_data and rsp_err are registered.
  - rsp_err clears on the next request acceptance.
  - rsp_data keeps its last value in IDLE.
- Handshake rules:
  - req_ready=0 in every state except IDLE; one outstanding request only.
  - The earliest next accept is the cycle after the RESP handshake.
- Latency, no busy:
  - Accept edge at cycle 0; ISSUE at cycles 1, 3, 5, 7; CAPTURE at cycles 2, 4, 6, 8.
  - rsp_valid first high in cycle 9.
  - Each busy cycle adds 1.
- Address wrap: base + idx wraps modulo 16 (e.g. base 14 reads 14, 15, 0, 1). Unaligned bases are legal.
- Simultaneous events:
  - req_valid during RESP is ignored (not accepted).
  - mem_busy rising in CAPTURE has no effect; the byte is sampled regardless.
  - mem_dout is sampled only in CAPTURE.
- Reset mid-operation: immediate abort. mem_rd drops asynchronously, no response is produced, and partial data is discarded.
- Timeout: counter width 8 bits; abort exactly when the count equals TIMEOUT.

Test Plan:
- Model memory byte i = 8'h10+i, no busy, request addr 0 -> mem_rd pulses at cycles 1, 3, 5, 7 with mem_addr 0, 1, 2, 3; rsp_valid at cycle 9 with rsp_data=32'h10111213, rsp_err=0.
- Request addr 14 -> mem_addr sequence 14, 15, 0, 1; rsp_data=32'h1E1F1011. Same with BIG_ENDIAN=0 -> 32'h11101F1E.
- mem_busy high for 3 cycles before the second byte -> mem_rd stays low during busy; rsp_valid at cycle 12; data is unchanged.
- mem_busy held high from the second byte onward, TIMEOUT=15 -> rsp_valid with rsp_err=1 and rsp_data=0 after exactly 15 busy cycles; next request clears rsp_err and completes normally.
- rsp_ready low for 4 cycles -> rsp_valid and rsp_data stable for all 4 cycles; req_valid held high meanwhile is not accepted (req_ready=0) and is accepted the cycle after the handshake.
- Assert rst=0 during the third ISSUE -> mem_rd and rsp_valid drop immediately; after release, req_ready=1 and a new read of addr 4 returns 32'h14151617.
